// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB arbiter and its requesters.
// Latency: n/a (types, constants and combinational helper functions only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

  localparam int NUM_REQ = 4;                   // ALU, MULT, LOAD, BRANCH
  localparam int XLEN    = 32;                  // result value width
  localparam int ROB_SZ  = 8;                   // legal tags are 1..ROB_SZ
  localparam int TAG_W   = $clog2(ROB_SZ + 1);  // tag 0 means "no broadcast"

  typedef logic [TAG_W-1:0] rob_tag_t;

  // What goes out on the CDB to the rob and reservation stations.
  typedef struct packed {
    rob_tag_t          rob_tag;
    logic [XLEN-1:0]   v;
  } cdb_rob_packet_t;

  // What a functional unit presents when it completes.
  typedef struct packed {
    logic              valid;
    rob_tag_t          rob_tag;
    logic [XLEN-1:0]   v;
  } fu_result_packet_t;

  // Distance of a tag from the rob head, in 0..ROB_SZ-1. Tags and head are
  // both 1-based, so the difference lies in -(ROB_SZ-1)..ROB_SZ-1; adding
  // ROB_SZ and folding once is enough.
  function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
    logic [TAG_W:0] diff;
    diff = {1'b0, tag} + (TAG_W+1)'(ROB_SZ) - {1'b0, head};
    if (diff >= (TAG_W+1)'(ROB_SZ)) begin
      diff = diff - (TAG_W+1)'(ROB_SZ);
    end
    return diff[TAG_W-1:0];
  endfunction

  // True when tag was allocated after ref_tag. Equal tags are not younger.
  function automatic logic rob_younger(input rob_tag_t tag, input rob_tag_t ref_tag,
                                       input rob_tag_t head);
    return rob_age(tag, head) > rob_age(ref_tag, head);
  endfunction

  function automatic logic rob_tag_legal(input rob_tag_t tag);
    return (tag != '0) && (tag <= TAG_W'(ROB_SZ));
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle between completion sources / rob control and the CDB arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_ready per source; the CDB side has no backpressure.
// Signals: req_valid/req_rob_tag/req_v/req_ready per source, squash_valid,
// squash_rob_tag, rob_head, and the registered cdb_valid/cdb_rob_tag/cdb_v.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  rob_tag_t [NUM_REQ-1:0]        req_rob_tag;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_v;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          squash_valid;
  rob_tag_t                      squash_rob_tag;
  rob_tag_t                      rob_head;

  logic                          cdb_valid;
  rob_tag_t                      cdb_rob_tag;
  logic [XLEN-1:0]               cdb_v;

  // Requester / rob side.
  modport master (
    output req_valid, req_rob_tag, req_v, squash_valid, squash_rob_tag, rob_head,
    input  req_ready, cdb_valid, cdb_rob_tag, cdb_v
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_rob_tag, req_v, squash_valid, squash_rob_tag, rob_head,
    output req_ready, cdb_valid, cdb_rob_tag, cdb_v
  );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; grant is one-hot or zero.
// Ports: req (request vector), rr_ptr (highest-priority index), grant (one-hot).
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the single CDB among NUM_REQ completion sources via one-entry holds
// and a round-robin pick. Latency: 2 cycles from accept to CDB broadcast.
// Backpressure: req_ready[i] drops while source i's hold is full and not granted.
// Ports: clock, reset (sync, active-low), bus (slave side of cdb_arbiter_if).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] hold_valid;
  cdb_rob_packet_t    hold_pkt [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;

  fu_result_packet_t  req_pkt [NUM_REQ];
  logic [NUM_REQ-1:0] kill;
  logic [NUM_REQ-1:0] in_keep;   // incoming entry is legal and survives any squash
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] xfer;

  logic               any_grant;
  logic [PTR_W-1:0]   grant_idx;
  cdb_rob_packet_t    grant_pkt;

  logic               cdb_valid_q;
  cdb_rob_packet_t    cdb_q;

  always_comb begin
    req_pkt = '{default: '0};
    kill    = '0;
    in_keep = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_pkt[i].valid   = bus.req_valid[i];
      req_pkt[i].rob_tag = bus.req_rob_tag[i];
      req_pkt[i].v       = bus.req_v[i];
      kill[i]    = bus.squash_valid && hold_valid[i] &&
                   rob_younger(hold_pkt[i].rob_tag, bus.squash_rob_tag, bus.rob_head);
      in_keep[i] = rob_tag_legal(req_pkt[i].rob_tag) &&
                   !(bus.squash_valid &&
                     rob_younger(req_pkt[i].rob_tag, bus.squash_rob_tag, bus.rob_head));
    end
  end

  // Killed holds are never candidates, so a squash can never be broadcast.
  assign cand = hold_valid & ~kill;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req    (cand),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  // A granted hold frees at this edge, so its source may refill it in the
  // same cycle and keep the CDB busy without a bubble.
  assign ready         = ~hold_valid | grant;
  assign bus.req_ready = ready;

  always_comb begin
    xfer = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      xfer[i] = req_pkt[i].valid && ready[i];
    end
  end

  always_comb begin
    any_grant = |grant;
    grant_idx = '0;
    grant_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
        grant_pkt = hold_pkt[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_valid  <= '0;
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer[i]) begin
          // Illegal or squashed arrivals are accepted but not held.
          hold_valid[i] <= in_keep[i];
        end else if (grant[i] || kill[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end

      if (any_grant) begin
        rr_ptr      <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        cdb_valid_q <= 1'b1;
        cdb_q       <= grant_pkt;
      end else begin
        cdb_valid_q <= 1'b0;
        cdb_q       <= '0;
      end
    end
  end

  // Payload needs no reset: it is only observed when hold_valid is set.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer[i]) begin
        hold_pkt[i].rob_tag <= req_pkt[i].rob_tag;
        hold_pkt[i].v       <= req_pkt[i].v;
      end
    end
  end

  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_rob_tag = cdb_q.rob_tag;
  assign bus.cdb_v       = cdb_q.v;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  cdb_rob_packet_t exp_q[$];

  rob_tag_t src_tag   [NUM_REQ][4];
  int       src_cnt   [NUM_REQ];
  int       src_start [NUM_REQ];

  function automatic logic [XLEN-1:0] vgen(input int s, input rob_tag_t t);
    return 32'hC0DE_0000 | (XLEN'(s) << 8) | XLEN'(t);
  endfunction

  function automatic void push_exp(input int s, input rob_tag_t t);
    cdb_rob_packet_t p;
    p.rob_tag = t;
    p.v       = vgen(s, t);
    exp_q.push_back(p);
  endfunction

  // Scoreboard: every broadcast must be the next expected one; idle cycles
  // must carry zero tag and value.
  always @(negedge clock) begin
    cdb_rob_packet_t e;
    if (bus.cdb_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL cdb_unexpected: got tag %0d v %h, expected no broadcast",
                 bus.cdb_rob_tag, bus.cdb_v);
      end else begin
        e = exp_q.pop_front();
        if (bus.cdb_rob_tag !== e.rob_tag || bus.cdb_v !== e.v)
          $display("FAIL cdb_order: got tag %0d v %h, expected tag %0d v %h",
                   bus.cdb_rob_tag, bus.cdb_v, e.rob_tag, e.v);
        else n_pass++;
      end
    end else begin
      n_checks++;
      if (bus.cdb_valid !== 1'b0 || bus.cdb_rob_tag !== '0 || bus.cdb_v !== '0)
        $display("FAIL cdb_idle: got valid %b tag %0d v %h, expected 0/0/0",
                 bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_v);
      else n_pass++;
    end
  end

  always @(posedge clock) begin
    if (reset === 1'b1) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] === 1'b1)
          assert (rob_tag_legal(bus.req_rob_tag[i]))
            else $error("illegal request tag %0d on source %0d", bus.req_rob_tag[i], i);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_req();
    bus.req_valid    = '0;
    bus.squash_valid = 1'b0;
  endtask

  task automatic drive_src(input int s, input rob_tag_t t);
    bus.req_valid[s]   = 1'b1;
    bus.req_rob_tag[s] = t;
    bus.req_v[s]       = vgen(s, t);
  endtask

  task automatic apply_reset();
    clear_req();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_idle(output int left);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(negedge clock);
      #1;
    end
    left = exp_q.size();
    repeat (4) tick();
  endtask

  // Presents each source's tag list, advancing a source only on transfer.
  task automatic feed(input int max_cyc, output int stuck);
    int idx [NUM_REQ];
    logic [NUM_REQ-1:0] x;
    int cyc;
    bit busy;
    for (int i = 0; i < NUM_REQ; i++) idx[i] = 0;
    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < max_cyc) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cyc >= src_start[i] && idx[i] < src_cnt[i]) drive_src(i, src_tag[i][idx[i]]);
        else bus.req_valid[i] = 1'b0;
      end
      @(negedge clock);
      x = bus.req_valid & bus.req_ready;
      tick();
      for (int i = 0; i < NUM_REQ; i++) if (x[i]) idx[i]++;
      cyc++;
      busy = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (idx[i] < src_cnt[i]) busy = 1'b1;
    end
    bus.req_valid = '0;
    stuck = busy ? 1 : 0;
  endtask

  task automatic test_reset();
    clear_req();
    bus.req_rob_tag    = '0;
    bus.req_v          = '0;
    bus.squash_rob_tag = '0;
    bus.rob_head       = rob_tag_t'(1);
    reset = 1'b0;
    tick();
    @(negedge clock);
    n_checks++;
    if (bus.cdb_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", bus.cdb_valid);
    else n_pass++;
    n_checks++;
    if (bus.cdb_rob_tag !== '0) $display("FAIL reset_tag: got %0d, expected 0", bus.cdb_rob_tag);
    else n_pass++;
    n_checks++;
    if (bus.cdb_v !== '0) $display("FAIL reset_v: got %h, expected 0", bus.cdb_v);
    else n_pass++;
    n_checks++;
    if (bus.req_ready !== 4'b1111) $display("FAIL reset_ready: got %b, expected 1111", bus.req_ready);
    else n_pass++;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single();
    int left;
    bus.req_valid[0]   = 1'b1;
    bus.req_rob_tag[0] = rob_tag_t'(3);
    bus.req_v[0]       = 32'h0000_00AA;
    begin
      cdb_rob_packet_t p;
      p.rob_tag = rob_tag_t'(3);
      p.v       = 32'h0000_00AA;
      exp_q.push_back(p);
    end
    @(negedge clock);
    n_checks++;
    if (bus.req_ready[0] !== 1'b1) $display("FAIL single_ready_pre: got %b, expected 1", bus.req_ready[0]);
    else n_pass++;
    tick();
    bus.req_valid[0] = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.req_ready[0] !== 1'b1) $display("FAIL single_ready_held: got %b, expected 1", bus.req_ready[0]);
    else n_pass++;
    n_checks++;
    if (bus.cdb_valid !== 1'b0) $display("FAIL single_latency_early: got %b, expected 0", bus.cdb_valid);
    else n_pass++;
    tick();
    @(negedge clock);
    n_checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_tag !== rob_tag_t'(3) || bus.cdb_v !== 32'hAA)
      $display("FAIL single_latency: got valid %b tag %0d v %h, expected 1/3/000000aa",
               bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_v);
    else n_pass++;
    tick();
    wait_idle(left);
    n_checks++;
    if (left !== 0) $display("FAIL single_drain: got %0d pending, expected 0", left);
    else n_pass++;
  endtask

  task automatic test_contention();
    int left;
    int stuck;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_cnt[i]    = 2;
      src_start[i]  = 0;
      src_tag[i][0] = rob_tag_t'(i + 1);
      src_tag[i][1] = rob_tag_t'(i + 5);
    end
    for (int t = 1; t <= 8; t++) push_exp((t - 1) % NUM_REQ, rob_tag_t'(t));
    fork
      feed(30, stuck);
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
          @(negedge clock);
          if (bus.cdb_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL contention_start: got no broadcast in 10 cycles, expected one");
        else n_pass++;
        for (int k = 1; k < 8 && seen; k++) begin
          @(negedge clock);
          n_checks++;
          if (bus.cdb_valid !== 1'b1)
            $display("FAIL contention_bubble: got valid %b at slot %0d, expected 1", bus.cdb_valid, k);
          else n_pass++;
        end
      end
    join
    n_checks++;
    if (stuck !== 0) $display("FAIL contention_feed: got sources stuck, expected all accepted");
    else n_pass++;
    wait_idle(left);
    n_checks++;
    if (left !== 0) $display("FAIL contention_drain: got %0d pending, expected 0", left);
    else n_pass++;
  endtask

  task automatic test_fairness();
    int left;
    int stuck;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_cnt[i]   = 0;
      src_start[i] = 0;
    end
    src_cnt[0] = 3;
    src_tag[0][0] = rob_tag_t'(1);
    src_tag[0][1] = rob_tag_t'(2);
    src_tag[0][2] = rob_tag_t'(3);
    src_cnt[2] = 1;
    src_tag[2][0] = rob_tag_t'(6);
    src_cnt[3] = 1;
    src_start[3] = 1;
    src_tag[3][0] = rob_tag_t'(7);
    // Source 2 wins from rr_ptr=1; rr_ptr=3 then favours source 3 over 0.
    push_exp(0, rob_tag_t'(1));
    push_exp(2, rob_tag_t'(6));
    push_exp(3, rob_tag_t'(7));
    push_exp(0, rob_tag_t'(2));
    push_exp(0, rob_tag_t'(3));
    feed(30, stuck);
    n_checks++;
    if (stuck !== 0) $display("FAIL fairness_feed: got sources stuck, expected all accepted");
    else n_pass++;
    wait_idle(left);
    n_checks++;
    if (left !== 0) $display("FAIL fairness_drain: got %0d pending, expected 0", left);
    else n_pass++;
  endtask

  task automatic test_squash();
    int left;
    apply_reset();
    bus.rob_head = rob_tag_t'(1);
    drive_src(0, rob_tag_t'(5));
    drive_src(1, rob_tag_t'(7));
    drive_src(2, rob_tag_t'(2));
    push_exp(2, rob_tag_t'(2));
    tick();
    bus.req_valid      = '0;
    bus.squash_valid   = 1'b1;
    bus.squash_rob_tag = rob_tag_t'(4);
    drive_src(3, rob_tag_t'(6));
    @(negedge clock);
    n_checks++;
    if (bus.req_ready !== 4'b1100) $display("FAIL squash_ready: got %b, expected 1100", bus.req_ready);
    else n_pass++;
    tick();
    clear_req();
    wait_idle(left);
    n_checks++;
    if (left !== 0) $display("FAIL squash_drain: got %0d pending, expected 0", left);
    else n_pass++;
  endtask

  task automatic test_wrap_age();
    int left;
    apply_reset();
    bus.rob_head = rob_tag_t'(7);
    drive_src(0, rob_tag_t'(2));
    drive_src(1, rob_tag_t'(8));
    drive_src(2, rob_tag_t'(1));
    push_exp(1, rob_tag_t'(8));
    push_exp(2, rob_tag_t'(1));
    tick();
    bus.req_valid      = '0;
    bus.squash_valid   = 1'b1;
    bus.squash_rob_tag = rob_tag_t'(1);
    @(negedge clock);
    n_checks++;
    if (bus.req_ready !== 4'b1010) $display("FAIL wrap_ready: got %b, expected 1010", bus.req_ready);
    else n_pass++;
    tick();
    clear_req();
    wait_idle(left);
    n_checks++;
    if (left !== 0) $display("FAIL wrap_drain: got %0d pending, expected 0", left);
    else n_pass++;
    bus.rob_head = rob_tag_t'(1);
  endtask

  task automatic test_reset_mid();
    drive_src(0, rob_tag_t'(1));
    drive_src(1, rob_tag_t'(2));
    drive_src(2, rob_tag_t'(3));
    tick();
    bus.req_valid = '0;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ($countones(bus.req_ready) != 2) $display("FAIL resetmid_full: got ready %b, expected two bits set", bus.req_ready);
    else n_pass++;
    tick();
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_rob_tag !== '0 || bus.cdb_v !== '0)
      $display("FAIL resetmid_cdb: got valid %b tag %0d v %h, expected 0/0/0",
               bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_v);
    else n_pass++;
    n_checks++;
    if (bus.req_ready !== 4'b1111) $display("FAIL resetmid_ready: got %b, expected 1111", bus.req_ready);
    else n_pass++;
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_squash();
    test_wrap_age();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single CDB between NUM_REQ functional-unit completion sources.
- Each source gets a one-entry holding register. A round-robin arbiter picks one held result per cycle and drives a registered CDB_ROB_PACKET-shaped output (rob_tag, v) to the rob and reservation stations.
- Honours branch squash so results younger than a mispredicted branch never broadcast.

Parameters:
- NUM_REQ, 4, number of completion sources (ALU, MULT, LOAD, BRANCH).
- XLEN, 32, result value width.
- ROB_SZ, 8, rob entries; valid tags 1..ROB_SZ, tag 0 = no broadcast.
- TAG_W, $clog2(ROB_SZ+1), rob tag width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQ  source i has a completed result.
- req_rob_tag  in  NUM_REQ x TAG_W  rob tag of source i result.
- req_v  in  NUM_REQ x XLEN  result value of source i.
- req_ready  out  NUM_REQ  source i may hand over a result this cycle.
- squash_valid  in  1  branch mispredict (branch_valid).
- squash_rob_tag  in  TAG_W  tag of mispredicted branch; strictly younger entries die.
- rob_head  in  TAG_W  current rob head, used for age compare.
- cdb_valid  out  1  registered; broadcast valid.
- cdb_rob_tag  out  TAG_W  registered; 0 when cdb_valid=0.
- cdb_v  out  XLEN  registered; 0 when cdb_valid=0.

Behaviour:
- Reset (reset==0 at posedge): all hold_valid=0, rr_ptr=0, cdb_valid=0, cdb_rob_tag=0, cdb_v=0. req_ready is combinational and reads all-1 while holds are empty. Reset mid-operation discards all held results.
- Handshake: req_ready[i] = !hold_valid[i] || grant[i]. A transfer occurs at the posedge when req_valid[i] && req_ready[i]; hold[i] loads {tag, v}. A source may keep req_valid high; data must be stable until the transfer.
- Age function: age(t) = (t - rob_head) mod ROB_SZ over tags 1..ROB_SZ. Entry t is younger than branch b iff age(t) > age(b). Tag equal to squash_rob_tag survives.
- Kill mask: kill[i] = squash_valid && hold_valid[i] && younger(hold_tag[i], squash_rob_tag).
- Grant: combinational. Candidates are hold_valid & ~kill. Scan from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...). The first candidate wins; grant is one-hot or zero.
- Posedge update, non-reset:
  - A granted entry's hold_valid clears. If the same source transfers at that edge, hold reloads with the new entry instead (back-to-back, no bubble).
  - Killed entries clear.
  - An incoming transfer whose tag is younger than an active squash is accepted (ready honoured) and discarded.
  - rr_ptr <= (granted index + 1) mod NUM_REQ. rr_ptr is unchanged when nothing is granted.
  - cdb_* <= granted hold contents with cdb_valid=1. With no grant, cdb_valid=0 and tag/value are 0.
- Latency: a result accepted at edge k is visible on the CDB at the earliest after edge k+1, i.e. 2 cycles. At most one broadcast per cycle.
- Fairness: a held candidate waits at most NUM_REQ-1 grants.
- Illegal input: req_valid with tag 0, or a tag > ROB_SZ, is illegal. The bench asserts it never occurs; RTL drops such entries.
- The current cdb_* output is never retracted. Squash affects only the next cycle's output.

Decomposition:
- Shared package (sys_defs.svh): ROB_TAG typedef, ROB_SZ constant, CDB_ROB_PACKET typedef, and an FU_RESULT_PACKET {valid, rob_tag, v} typedef for requester inputs.
- One sub-module: rr_arbiter (NUM_REQ-wide request vector plus rr_ptr in, one-hot grant out, purely combinational). It is reused by the later issue-select logic.
- The age compare is a package function rob_younger(tag, ref, head).

Test Plan:
- Single source: req0 tag=3 v=0xAA at edge 1 -> cdb_valid=1, cdb_rob_tag=3, cdb_v=0xAA in the cycle after edge 2; req_ready0=1 throughout.
- Contention: all 4 sources valid, tags 1..4, rr_ptr=0, held continuously -> broadcasts in order 1,2,3,4 on consecutive cycles. New tags 5..8 are re-presented and continue 5,6,7,8 with no bubble.
- Fairness: source 0 held valid every cycle, source 2 valid once -> source 2 granted within 2 cycles of holding; rr_ptr=3 after its grant.
- Squash: head=1, held tags 2,5,7; squash_valid, squash_rob_tag=4 -> tags 5 and 7 cleared, tag 2 broadcast next; no CDB tag 5 or 7 ever appears.
- Wrap-around age: head=7, held tags 8 and 2; squash_rob_tag=1 -> tag 8 survives (age 1), tag 2 killed (age 3 > age 2).
- Reset mid-stream: 3 holds full, drive reset=0 for one edge -> next cycle cdb_valid=0, tag=0, req_ready=4'b1111, no stale broadcast afterwards.
